// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: redirect > MDU busy > load-use.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES   = 1,
    parameter int unsigned MDU_MAX_CYCLES = 64
) (
    input  logic        clkIn,
    input  logic        resetIn,
    input  logic [4:0]  IDRsIn,
    input  logic [4:0]  IDRtIn,
    input  logic        IDUsesRsIn,
    input  logic        IDUsesRtIn,
    input  logic        EXMemReadIn,
    input  logic        EXRegWriteIn,
    input  logic [4:0]  EXRdIn,
    input  logic        EXRedirectIn,
    input  logic        mduStartIn,
    input  logic        mduDoneIn,
    output logic        stallPCOut,
    output logic        stallIFIDOut,
    output logic        flushIFIDOut,
    output logic        stallIDEXOut,
    output logic        flushIDEXOut,
    output logic        flushEXMEMOut,
    output logic        errOut,
    output logic [31:0] stallCntOut,
    output logic [31:0] flushCntOut
);

    localparam int unsigned FLUSH_W = 4;
    localparam int unsigned MDU_W   = $clog2(MDU_MAX_CYCLES + 1);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] FLUSH    = 2'd1;
    localparam logic [1:0] MDU_WAIT = 2'd2;

    logic [1:0]         state;
    logic [1:0]         stateNext;
    logic [FLUSH_W-1:0] flushCnt;
    logic [FLUSH_W-1:0] flushCntNext;
    logic [MDU_W-1:0]   mduCnt;
    logic [MDU_W-1:0]   mduCntNext;
    logic               errNext;
    logic               loadUse;

    assign loadUse = EXMemReadIn && EXRegWriteIn && (EXRdIn != 5'd0) &&
                     ((IDUsesRsIn && (IDRsIn == EXRdIn)) ||
                      (IDUsesRtIn && (IDRtIn == EXRdIn)));

    // State, counters and the registered error pulse
    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state    <= RUN;
            flushCnt <= '0;
            mduCnt   <= '0;
            errOut   <= 1'b0;
        end else begin
            state    <= stateNext;
            flushCnt <= flushCntNext;
            mduCnt   <= mduCntNext;
            errOut   <= errNext;
        end
    end

    // Next state and same-cycle control outputs
    always_comb begin
        stateNext     = state;
        flushCntNext  = flushCnt;
        mduCntNext    = mduCnt;
        errNext       = 1'b0;
        stallPCOut    = 1'b0;
        stallIFIDOut  = 1'b0;
        flushIFIDOut  = 1'b0;
        stallIDEXOut  = 1'b0;
        flushIDEXOut  = 1'b0;
        flushEXMEMOut = 1'b0;
        case (state)
            RUN: begin
                if (EXRedirectIn) begin
                    flushIFIDOut = 1'b1;
                    flushIDEXOut = 1'b1;
                    errNext      = mduStartIn;
                    if (FLUSH_CYCLES > 1) begin
                        stateNext    = FLUSH;
                        flushCntNext = FLUSH_W'(FLUSH_CYCLES - 1);
                    end
                end else if (mduStartIn && !mduDoneIn) begin
                    stallPCOut    = 1'b1;
                    stallIFIDOut  = 1'b1;
                    stallIDEXOut  = 1'b1;
                    flushEXMEMOut = 1'b1;
                    stateNext     = MDU_WAIT;
                    mduCntNext    = MDU_W'(1);
                end else if (loadUse) begin
                    stallPCOut   = 1'b1;
                    stallIFIDOut = 1'b1;
                    flushIDEXOut = 1'b1;
                end
            end
            FLUSH: begin
                flushIFIDOut = 1'b1;
                if (EXRedirectIn) begin
                    flushIDEXOut = 1'b1;
                    flushCntNext = FLUSH_W'(FLUSH_CYCLES - 1);
                end else if (flushCnt <= FLUSH_W'(1)) begin
                    flushCntNext = '0;
                    stateNext    = RUN;
                end else begin
                    flushCntNext = flushCnt - FLUSH_W'(1);
                end
            end
            MDU_WAIT: begin
                if (mduDoneIn) begin
                    mduCntNext = '0;
                    stateNext  = RUN;
                end else begin
                    stallPCOut    = 1'b1;
                    stallIFIDOut  = 1'b1;
                    stallIDEXOut  = 1'b1;
                    flushEXMEMOut = 1'b1;
                    // Watchdog: give up on a hung MDU and flag it
                    if (mduCnt >= MDU_W'(MDU_MAX_CYCLES)) begin
                        mduCntNext = '0;
                        stateNext  = RUN;
                        errNext    = 1'b1;
                    end else begin
                        mduCntNext = mduCnt + MDU_W'(1);
                    end
                end
            end
            default: begin
                stateNext = RUN;
            end
        endcase
        if (resetIn) begin
            stallPCOut    = 1'b0;
            stallIFIDOut  = 1'b0;
            flushIFIDOut  = 1'b0;
            stallIDEXOut  = 1'b0;
            flushIDEXOut  = 1'b0;
            flushEXMEMOut = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCnt;
    logic [31:0] flushCnt32;

    // Free-running wrap-around event counters
    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            stallCnt   <= '0;
            flushCnt32 <= '0;
        end else begin
            if (stallPCOut) begin
                stallCnt <= stallCnt + 32'd1;
            end
            if (flushIFIDOut) begin
                flushCnt32 <= flushCnt32 + 32'd1;
            end
        end
    end

    assign stallCntOut = stallCnt;
    assign flushCntOut = flushCnt32;
`else
    assign stallCntOut = '0;
    assign flushCntOut = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int FC  = 3;
    localparam int MAX = 8;

    logic        clkIn = 1'b0;
    logic        resetIn = 1'b1;
    logic [4:0]  IDRsIn = '0, IDRtIn = '0, EXRdIn = '0;
    logic        IDUsesRsIn = 1'b0, IDUsesRtIn = 1'b0;
    logic        EXMemReadIn = 1'b0, EXRegWriteIn = 1'b0;
    logic        EXRedirectIn = 1'b0, mduStartIn = 1'b0, mduDoneIn = 1'b0;
    logic        stallPCOut, stallIFIDOut, flushIFIDOut, stallIDEXOut;
    logic        flushIDEXOut, flushEXMEMOut, errOut;
    logic [31:0] stallCntOut, flushCntOut;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MDU_MAX_CYCLES(MAX)) dut (
        .clkIn(clkIn), .resetIn(resetIn),
        .IDRsIn(IDRsIn), .IDRtIn(IDRtIn),
        .IDUsesRsIn(IDUsesRsIn), .IDUsesRtIn(IDUsesRtIn),
        .EXMemReadIn(EXMemReadIn), .EXRegWriteIn(EXRegWriteIn), .EXRdIn(EXRdIn),
        .EXRedirectIn(EXRedirectIn), .mduStartIn(mduStartIn), .mduDoneIn(mduDoneIn),
        .stallPCOut(stallPCOut), .stallIFIDOut(stallIFIDOut), .flushIFIDOut(flushIFIDOut),
        .stallIDEXOut(stallIDEXOut), .flushIDEXOut(flushIDEXOut),
        .flushEXMEMOut(flushEXMEMOut), .errOut(errOut),
        .stallCntOut(stallCntOut), .flushCntOut(flushCntOut)
    );

    always #5 clkIn = ~clkIn;

    typedef struct packed {
        logic [6:0]  ctl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: remaining flush cycles, MDU wait index, pending error, event totals
    int      mFlushLeft = 0;
    int      mMduWait   = 0;
    logic    mErr       = 1'b0;
    longint  mSc        = 0;
    longint  mFc        = 0;

    task automatic drive(input logic rst, input logic redir, input logic start,
                         input logic done, input logic memRd, input logic regWr,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                         input logic uRs, input logic uRt);
        logic sPC, sIFID, fIFID, sIDEX, fIDEX, fEXMEM, lu, errN;
        exp_t e;
        @(posedge clkIn);
        #1;
        resetIn = rst; EXRedirectIn = redir; mduStartIn = start; mduDoneIn = done;
        EXMemReadIn = memRd; EXRegWriteIn = regWr; EXRdIn = rd;
        IDRsIn = rs; IDRtIn = rt; IDUsesRsIn = uRs; IDUsesRtIn = uRt;

        lu = memRd && regWr && rd != 0 && ((uRs && rs == rd) || (uRt && rt == rd));
        {sPC, sIFID, fIFID, sIDEX, fIDEX, fEXMEM} = '0;
        errN = 1'b0;
        if (mMduWait > 0) begin
            if (done) mMduWait = 0;
            else begin
                {sPC, sIFID, sIDEX, fEXMEM} = '1;
                if (mMduWait == MAX) begin mMduWait = 0; errN = 1'b1; end
                else mMduWait++;
            end
        end else if (mFlushLeft > 0) begin
            fIFID = 1'b1;
            if (redir) begin fIDEX = 1'b1; mFlushLeft = FC - 1; end
            else mFlushLeft--;
        end else if (redir) begin
            fIFID = 1'b1; fIDEX = 1'b1; errN = start; mFlushLeft = FC - 1;
        end else if (start && !done) begin
            {sPC, sIFID, sIDEX, fEXMEM} = '1;
            mMduWait = 1;
        end else if (lu) begin
            sPC = 1'b1; sIFID = 1'b1; fIDEX = 1'b1;
        end
        if (rst) {sPC, sIFID, fIFID, sIDEX, fIDEX, fEXMEM} = '0;

        e.ctl = {sPC, sIFID, fIFID, sIDEX, fIDEX, fEXMEM, mErr};
`ifdef HAZARD_PERF_CNT_EN
        e.sc = mSc[31:0];
        e.fc = mFc[31:0];
`else
        e.sc = '0;
        e.fc = '0;
`endif
        expQ.push_back(e);

        if (rst) begin
            mFlushLeft = 0; mMduWait = 0; mErr = 1'b0; mSc = 0; mFc = 0;
        end else begin
            mErr = errN;
            if (sPC) mSc++;
            if (fIFID) mFc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a full output set
    always @(negedge clkIn) begin
        exp_t e;
        logic [6:0] act;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            act = {stallPCOut, stallIFIDOut, flushIFIDOut, stallIDEXOut,
                   flushIDEXOut, flushEXMEMOut, errOut};
            checks++;
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL ctl t=%0t got=%b want=%b", $time, act, e.ctl);
            end
            checks++;
            if (stallCntOut !== e.sc) begin
                errors++;
                $display("FAIL stallCnt t=%0t got=%0d want=%0d", $time, stallCntOut, e.sc);
            end
            checks++;
            if (flushCntOut !== e.fc) begin
                errors++;
                $display("FAIL flushCnt t=%0t got=%0d want=%0d", $time, flushCntOut, e.fc);
            end
        end
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(2);
        // load-use on rs, then the same with rd=0
        drive(0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd7, 1, 0);
        idle(1);
        drive(0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 1);
        drive(0, 0, 0, 0, 1, 1, 5'd9, 5'd1, 5'd9, 0, 1);
        // redirect pulse, redirect+LU, redirect+mduStart
        drive(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(3);
        drive(0, 1, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        idle(3);
        drive(0, 1, 1, 0, 0, 1, 5'd3, 5'd0, 5'd0, 0, 0);
        idle(3);
        // redirect again during FLUSH
        drive(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(4);
        // MDU: start, 4 wait cycles, done
        drive(0, 0, 1, 0, 0, 1, 5'd4, 5'd0, 5'd0, 0, 0);
        idle(4);
        drive(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        drive(0, 0, 1, 1, 0, 1, 5'd4, 5'd0, 5'd0, 0, 0);
        idle(1);
        // watchdog: done never comes
        drive(0, 0, 1, 0, 0, 1, 5'd4, 5'd0, 5'd0, 0, 0);
        idle(MAX + 3);
        // reset in the middle of MDU_WAIT
        drive(0, 0, 1, 0, 0, 1, 5'd4, 5'd0, 5'd0, 0, 0);
        idle(3);
        drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(2);
        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic rst, redir, start, done, memRd;
            rst   = ($urandom_range(0, 149) == 0);
            redir = ($urandom_range(0, 9) == 0);
            start = ($urandom_range(0, 7) == 0);
            done  = ($urandom_range(0, 4) == 0);
            memRd = start ? 1'b0 : 1'($urandom_range(0, 1));
            drive(rst, redir, start, done, memRd, 1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end
        idle(2);
        for (int i = 0; i < 5 && expQ.size() != 0; i++) @(negedge clkIn);
        @(posedge clkIn);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
